truth_table_sequencer: RTL

- Self-test controller for a 3-input gate-level combinational function block with inputs X, Y, Z and output F.
- On start, drives all 8 input vectors in order {X,Y,Z} = 0..7.
- Waits a programmable settle time per vector so gate delays resolve, then samples F into an 8-bit truth table.
- Compares the table against an expected constant; sits beside the function block in lab top-levels and replaces hand-written initial-block stimulus.

---
 rtl/tts_pkg.sv | 16 +
 rtl/tts_settle_timer.sv | 30 +++
 rtl/truth_table_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table self-test sequencer.
package tts_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } tts_state_t;

  // Golden table for F = XZ + Y'Z + X'YZ', bit i = F at {X,Y,Z} = i.
  localparam logic [7:0] TTS_DEFAULT_EXPECTED = 8'hA6;
  localparam int         TTS_NUM_VECTORS      = 8;

endpackage

// File: rtl/tts_settle_timer.sv
// Loadable 4-bit down-counter that times the settle window after each vector.
// expired is high while the count sits at 1, i.e. on the last settle cycle.
module tts_settle_timer
  import tts_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] count_r;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != 4'd0) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == 4'd1);

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-test controller: sweeps {X,Y,Z} = 0..7 into a 3-input function block,
// waits SETTLE_CYCLES per vector, samples F into table_out and compares it
// with EXPECTED. Build option TTS_ABORT_ON_MISMATCH_EN ends the sweep at the
// first mismatching vector instead of running all eight.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED      = TTS_DEFAULT_EXPECTED
)
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic       F,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [2:0] fail_idx
);

  localparam logic [3:0] SETTLE_VAL = SETTLE_CYCLES[3:0];
  localparam logic [2:0] LAST_IDX   = 3'(TTS_NUM_VECTORS - 1);

  if ((SETTLE_CYCLES < 0) || (SETTLE_CYCLES > 15)) begin : g_settle_range
    $error("SETTLE_CYCLES must lie in 0..15");
  end

  tts_state_t state_r;
  logic [2:0] idx_r;
  logic [2:0] xyz_r;
  logic       busy_r;
  logic       done_r;
  logic [7:0] table_r;
  logic       pass_r;
  logic [2:0] fail_idx_r;
  logic       mismatch_r;

  logic       timer_load_s;
  logic       timer_expired_s;
  logic       first_miss_s;

  tts_settle_timer u_timer (
    .clock    (clock),
    .reset_L  (reset_L),
    .load     (timer_load_s),
    .load_val (SETTLE_VAL),
    .expired  (timer_expired_s)
  );

  // Arm the settle timer during DRIVE; flag the first vector that disagrees.
  always_comb begin
    timer_load_s = 1'b0;
    first_miss_s = 1'b0;
    if (state_r == DRIVE) begin
      timer_load_s = 1'b1;
    end else begin
      timer_load_s = 1'b0;
    end
    if ((F != EXPECTED[idx_r]) && !mismatch_r) begin
      first_miss_s = 1'b1;
    end else begin
      first_miss_s = 1'b0;
    end
  end

  // Sequencer FSM; every output is a register. The vector is applied on the
  // edge that enters DRIVE so it has DRIVE + SETTLE cycles to propagate.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_r    <= IDLE;
      idx_r      <= 3'd0;
      xyz_r      <= 3'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      table_r    <= 8'h00;
      pass_r     <= 1'b0;
      fail_idx_r <= 3'd0;
      mismatch_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= DRIVE;
            idx_r      <= 3'd0;
            xyz_r      <= 3'd0;
            busy_r     <= 1'b1;
            table_r    <= 8'h00;
            pass_r     <= 1'b0;
            fail_idx_r <= 3'd0;
            mismatch_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        DRIVE: begin
          if (SETTLE_VAL == 4'd0) begin
            state_r <= SAMPLE;
          end else begin
            state_r <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_expired_s) begin
            state_r <= SAMPLE;
          end else begin
            state_r <= SETTLE;
          end
        end
        SAMPLE: begin
          table_r[idx_r] <= F;
          if (first_miss_s) begin
            fail_idx_r <= idx_r;
            mismatch_r <= 1'b1;
          end
`ifdef TTS_ABORT_ON_MISMATCH_EN
          if ((idx_r == LAST_IDX) || first_miss_s) begin
`else
          if (idx_r == LAST_IDX) begin
`endif
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + 3'd1;
            xyz_r   <= idx_r + 3'd1;
            state_r <= DRIVE;
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          pass_r  <= ~mismatch_r;
          busy_r  <= 1'b0;
          xyz_r   <= 3'd0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          xyz_r   <= 3'd0;
        end
      endcase
    end
  end

  assign X         = xyz_r[2];
  assign Y         = xyz_r[1];
  assign Z         = xyz_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign table_out = table_r;
  assign pass      = pass_r;
  assign fail_idx  = fail_idx_r;

endmodule
